// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST scheduler slice: FSM state encoding,
// requester mode encodings and the engine's step/counter geometry.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        SETTLE,
        REPORT
    } sched_state_e;

    // Mode 1x (bit 1 set) means pattern 0 followed by pattern 1.
    localparam logic [1:0] MODE_PAT0 = 2'b00;
    localparam logic [1:0] MODE_PAT1 = 2'b01;

    localparam int BIST_N_STEPS = 17;
    localparam int BIST_CNT_W   = 5;

endpackage

// File: rtl/bist_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant, pointer remembers the last
// requester served and only moves when a grant is actually taken.
module bist_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_gnt
);

    logic r_last;

    // On a tie the requester that was not served last wins.
    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = r_last ? 2'b01 : 2'b10;
        end
    end

    // Reset value 1 makes requester 0 the first winner of a tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (i_advance) begin
            r_last <= o_gnt[1];
        end
    end

endmodule

// File: rtl/bist_sched.sv
// Shares the BIST engine between the TAP (req 0) and power-on self-test (req 1).
// Optional WAIT watchdog enabled by defining BIST_SCHED_TIMEOUT_EN.
module bist_sched
    import bist_pkg::*;
#(
    parameter int N_STEPS     = BIST_N_STEPS,
    parameter int CNT_W       = BIST_CNT_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_i,
    input  logic [1:0]       mode0_i,
    input  logic [1:0]       mode1_i,
    output logic [1:0]       gnt_o,
    output logic [1:0]       done_o,
    output logic             busy_o,
    output logic             pass_o,
    output logic [1:0]       result_o,
    output logic             timeout_o,
    output logic             bist_start_o,
    output logic             bist_pattern_o,
    input  logic             bist_success_i,
    input  logic [CNT_W-1:0] bist_duration_i
);

    sched_state_e r_state;
    sched_state_e w_next;

    logic       r_id;
    logic       r_both;
    logic       r_pat;
    logic [1:0] r_result;
    logic [1:0] r_exec;
    logic       r_pass;
    logic       r_timeout;

    logic [1:0] w_arbReq;
    logic [1:0] w_gnt;
    logic       w_grant;
    logic [1:0] w_mode;
    logic [1:0] w_resNext;
    logic [1:0] w_execNext;

`ifdef BIST_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] r_waitCnt;
    logic [TO_W-1:0] w_waitInc;
    assign w_waitInc = r_waitCnt + 1'b1;
`endif

    // Requests are only offered to the arbiter while idle and out of reset,
    // so a grant can never appear during a run or while rst_n is low.
    assign w_arbReq = (r_state == IDLE) ? (req_i & {2{rst_n}}) : 2'b00;
    assign w_grant  = |w_gnt;
    assign w_mode   = w_gnt[1] ? mode1_i : mode0_i;

    bist_rr_arb u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (w_arbReq),
        .i_advance (w_grant),
        .o_gnt     (w_gnt)
    );

    always_comb begin
        w_resNext         = r_result;
        w_execNext        = r_exec;
        w_resNext[r_pat]  = bist_success_i;
        w_execNext[r_pat] = 1'b1;
    end

    always_comb begin
        w_next       = r_state;
        bist_start_o = 1'b0;
        done_o       = 2'b00;
        case (r_state)
            IDLE:   if (w_grant) w_next = START;
            START: begin
                bist_start_o = 1'b1;
                w_next       = WAIT;
            end
            WAIT: begin
                if (bist_duration_i == CNT_W'(N_STEPS)) w_next = SETTLE;
`ifdef BIST_SCHED_TIMEOUT_EN
                else if (w_waitInc == TO_W'(TIMEOUT_CYC)) w_next = REPORT;
`endif
            end
            SETTLE: w_next = (r_both && !r_pat) ? START : REPORT;
            REPORT: begin
                done_o = r_id ? 2'b10 : 2'b01;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Run context: latched at grant, results folded in at each SETTLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id      <= 1'b0;
            r_both    <= 1'b0;
            r_pat     <= 1'b0;
            r_result  <= 2'b00;
            r_exec    <= 2'b00;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
        end else if (w_grant) begin
            r_id      <= w_gnt[1];
            r_both    <= w_mode[1];
            r_pat     <= (w_mode == MODE_PAT1);
            r_result  <= 2'b00;
            r_exec    <= 2'b00;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
        end else if (r_state == SETTLE) begin
            r_result <= w_resNext;
            r_exec   <= w_execNext;
            if (w_next == REPORT) begin
                r_pass <= &(w_resNext | ~w_execNext);
            end else begin
                r_pat <= 1'b1;
            end
        end
`ifdef BIST_SCHED_TIMEOUT_EN
        else if (r_state == WAIT && w_next == REPORT) begin
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
        end
`endif
    end

`ifdef BIST_SCHED_TIMEOUT_EN
    // Counts completed WAIT cycles; held at zero outside WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waitCnt <= '0;
        end else if (r_state == WAIT) begin
            r_waitCnt <= w_waitInc;
        end else begin
            r_waitCnt <= '0;
        end
    end
    assign timeout_o = r_timeout;
`else
    assign timeout_o = 1'b0;
`endif

    assign gnt_o          = w_gnt;
    assign busy_o         = (r_state != IDLE) || w_grant;
    assign pass_o         = r_pass;
    assign result_o       = r_result;
    assign bist_pattern_o = r_pat;

endmodule

// File: tb/tb_bist_sched.sv
// Directed bench for bist_sched with a small behavioural BIST engine model.
// Timeout expectations follow BIST_SCHED_TIMEOUT_EN.
module tb_bist_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_i = 2'b00;
    logic [1:0] mode0_i = 2'b00;
    logic [1:0] mode1_i = 2'b00;
    logic [1:0] gnt_o;
    logic [1:0] done_o;
    logic       busy_o;
    logic       pass_o;
    logic [1:0] result_o;
    logic       timeout_o;
    logic       bist_start_o;
    logic       bist_pattern_o;
    logic       bist_success_i;
    logic [4:0] bist_duration_i;

    logic [4:0] dur = 5'd0;
    logic       engPat = 1'b0;
    logic [1:0] engFail = 2'b00;
    logic       stuck = 1'b0;

    int total = 0;
    int bad = 0;

    bist_sched dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_i           (req_i),
        .mode0_i         (mode0_i),
        .mode1_i         (mode1_i),
        .gnt_o           (gnt_o),
        .done_o          (done_o),
        .busy_o          (busy_o),
        .pass_o          (pass_o),
        .result_o        (result_o),
        .timeout_o       (timeout_o),
        .bist_start_o    (bist_start_o),
        .bist_pattern_o  (bist_pattern_o),
        .bist_success_i  (bist_success_i),
        .bist_duration_i (bist_duration_i)
    );

    always #5 clk = ~clk;

    // Engine model: clears on start, counts to 17 and saturates (or sticks at 3).
    always @(posedge clk) begin
        if (bist_start_o) begin
            dur    <= 5'd0;
            engPat <= bist_pattern_o;
        end else if (stuck) begin
            dur <= 5'd3;
        end else if (dur < 5'd17) begin
            dur <= dur + 5'd1;
        end
    end

    assign bist_duration_i = dur;
    assign bist_success_i  = (dur == 5'd17) ? ~engFail[engPat] : 1'b0;

    task automatic doGrant(input logic [1:0] req, input logic [1:0] m0, input logic [1:0] m1);
        @(negedge clk);
        req_i   = req;
        mode0_i = m0;
        mode1_i = m1;
        #1;
    endtask

    // Steps cycle by cycle after a grant and records what it sees; no checks here.
    task automatic runRun(input int budget, input logic dropReq,
                          output int doneAt, output logic [1:0] doneVal,
                          output int nStarts, output int startAt0, output int startAt1,
                          output logic pat0, output logic pat1);
        doneAt = -1; doneVal = 2'b00; nStarts = 0;
        startAt0 = -1; startAt1 = -1; pat0 = 1'b0; pat1 = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            #1;
            if (k == 1 && dropReq) req_i = 2'b00;
            if (bist_start_o) begin
                if (nStarts == 0) begin startAt0 = k; pat0 = bist_pattern_o; end
                else if (nStarts == 1) begin startAt1 = k; pat1 = bist_pattern_o; end
                nStarts++;
            end
            if (done_o != 2'b00) begin
                doneAt = k;
                doneVal = done_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_i = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL reset_gnt: got %b want 00", gnt_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        total++; if (done_o !== 2'b00) begin bad++; $display("FAIL reset_done: got %b want 00", done_o); end
        total++; if ({pass_o, result_o, timeout_o} !== 4'b0000) begin bad++; $display("FAIL reset_status: got %b want 0000", {pass_o, result_o, timeout_o}); end
        total++; if ({bist_start_o, bist_pattern_o} !== 2'b00) begin bad++; $display("FAIL reset_engine: got %b want 00", {bist_start_o, bist_pattern_o}); end
        req_i = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int da, ns, s0, s1; logic [1:0] dv; logic p0, p1;
        engFail = 2'b00;
        doGrant(2'b01, 2'b00, 2'b00);
        total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL single_gnt: got %b want 01", gnt_o); end
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy_o); end
        runRun(40, 1'b1, da, dv, ns, s0, s1, p0, p1);
        total++; if (da !== 21) begin bad++; $display("FAIL single_latency: got %0d want 21", da); end
        total++; if (dv !== 2'b01) begin bad++; $display("FAIL single_done: got %b want 01", dv); end
        total++; if (ns !== 1 || s0 !== 1 || p0 !== 1'b0) begin bad++; $display("FAIL single_start: got n=%0d at=%0d pat=%b want n=1 at=1 pat=0", ns, s0, p0); end
        total++; if ({pass_o, result_o, timeout_o} !== 4'b1010) begin bad++; $display("FAIL single_status: got %b want 1010", {pass_o, result_o, timeout_o}); end
        @(negedge clk); #1;
        total++; if ({busy_o, done_o, pass_o, result_o} !== 6'b000101) begin bad++; $display("FAIL single_hold: got %b want 000101", {busy_o, done_o, pass_o, result_o}); end
    endtask

    task automatic test_pattern1();
        int da, ns, s0, s1; logic [1:0] dv; logic p0, p1;
        engFail = 2'b00;
        doGrant(2'b01, 2'b01, 2'b00);
        total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL pat1_gnt: got %b want 01", gnt_o); end
        runRun(40, 1'b1, da, dv, ns, s0, s1, p0, p1);
        total++; if (da !== 21 || ns !== 1 || p0 !== 1'b1) begin bad++; $display("FAIL pat1_run: got at=%0d n=%0d pat=%b want at=21 n=1 pat=1", da, ns, p0); end
        total++; if ({pass_o, result_o} !== 3'b110) begin bad++; $display("FAIL pat1_status: got %b want 110", {pass_o, result_o}); end
    endtask

    task automatic test_both_fail();
        int da, ns, s0, s1; logic [1:0] dv; logic p0, p1;
        engFail = 2'b10;
        doGrant(2'b10, 2'b00, 2'b10);
        total++; if (gnt_o !== 2'b10) begin bad++; $display("FAIL both_gnt: got %b want 10", gnt_o); end
        runRun(60, 1'b1, da, dv, ns, s0, s1, p0, p1);
        total++; if (ns !== 2 || (s1 - s0) !== 20) begin bad++; $display("FAIL both_starts: got n=%0d gap=%0d want n=2 gap=20", ns, s1 - s0); end
        total++; if (p0 !== 1'b0 || p1 !== 1'b1) begin bad++; $display("FAIL both_patterns: got %b%b want 01", p0, p1); end
        total++; if (da !== 41 || dv !== 2'b10) begin bad++; $display("FAIL both_done: got at=%0d val=%b want at=41 val=10", da, dv); end
        total++; if ({pass_o, result_o} !== 3'b001) begin bad++; $display("FAIL both_status: got %b want 001", {pass_o, result_o}); end
        engFail = 2'b00;
    endtask

    task automatic test_back_to_back();
        int da, ns, s0, s1; logic [1:0] dv; logic p0, p1;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        doGrant(2'b11, 2'b00, 2'b00);
        total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL b2b_first_gnt: got %b want 01", gnt_o); end
        runRun(40, 1'b0, da, dv, ns, s0, s1, p0, p1);
        total++; if (da !== 21 || dv !== 2'b01) begin bad++; $display("FAIL b2b_first_done: got at=%0d val=%b want at=21 val=01", da, dv); end
        @(negedge clk); #1;
        total++; if (gnt_o !== 2'b10) begin bad++; $display("FAIL b2b_second_gnt: got %b want 10", gnt_o); end
        runRun(40, 1'b1, da, dv, ns, s0, s1, p0, p1);
        total++; if (da !== 21 || dv !== 2'b10) begin bad++; $display("FAIL b2b_second_done: got at=%0d val=%b want at=21 val=10", da, dv); end
    endtask

    task automatic test_stuck();
        int da, ns, s0, s1; logic [1:0] dv; logic p0, p1;
        stuck = 1'b1;
        doGrant(2'b01, 2'b10, 2'b00);
        runRun(100, 1'b1, da, dv, ns, s0, s1, p0, p1);
        total++; if (ns !== 1) begin bad++; $display("FAIL stuck_starts: got %0d want 1", ns); end
`ifdef BIST_SCHED_TIMEOUT_EN
        total++; if (da !== 66 || dv !== 2'b01) begin bad++; $display("FAIL stuck_timeout_done: got at=%0d val=%b want at=66 val=01", da, dv); end
        total++; if ({timeout_o, pass_o, result_o} !== 4'b1000) begin bad++; $display("FAIL stuck_timeout_status: got %b want 1000", {timeout_o, pass_o, result_o}); end
`else
        total++; if (da !== -1) begin bad++; $display("FAIL stuck_no_done: got done at %0d want none", da); end
        total++; if (busy_o !== 1'b1 || timeout_o !== 1'b0) begin bad++; $display("FAIL stuck_busy: got busy=%b to=%b want busy=1 to=0", busy_o, timeout_o); end
`endif
    endtask

    task automatic test_reset_mid();
        int da, ns, s0, s1, doneSeen; logic [1:0] dv; logic p0, p1;
        @(negedge clk); rst_n = 1'b0; stuck = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        doGrant(2'b10, 2'b00, 2'b00);
        total++; if (gnt_o !== 2'b10) begin bad++; $display("FAIL mid_gnt: got %b want 10", gnt_o); end
        req_i = 2'b00;
        repeat (5) @(negedge clk);
        req_i = 2'b11;
        rst_n = 1'b0;
        #1;
        total++; if ({gnt_o, done_o, busy_o, pass_o, result_o, timeout_o, bist_start_o, bist_pattern_o} !== 11'b0)
            begin bad++; $display("FAIL mid_reset_outputs: got %b want 0", {gnt_o, done_o, busy_o, pass_o, result_o, timeout_o, bist_start_o, bist_pattern_o}); end
        doneSeen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            if (done_o != 2'b00 || busy_o) doneSeen++;
        end
        total++; if (doneSeen !== 0) begin bad++; $display("FAIL mid_reset_quiet: got %0d active cycles want 0", doneSeen); end
        rst_n = 1'b1;
        #1;
        total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL mid_regrant: got %b want 01", gnt_o); end
        runRun(40, 1'b1, da, dv, ns, s0, s1, p0, p1);
        total++; if (da !== 21 || dv !== 2'b01) begin bad++; $display("FAIL mid_rerun: got at=%0d val=%b want at=21 val=01", da, dv); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_pattern1();
        test_both_fail();
        test_back_to_back();
        test_stuck();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
